parity_gen_chk: RTL

//  Parametrised UART parity unit serving both directions. TX: masked parallel

---
 rtl/uart_pkg.sv | 38 +++
 rtl/parity_tree.sv | 20 ++
 rtl/parity_gen_chk.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART parity definitions: parity mode and RX frame state encodings,
// the latched frame configuration, and the mode-to-parity-bit mapping.
package uart_pkg;

  localparam int unsigned LEN_W = 5;

  typedef enum logic [1:0] {
    PAR_ODD   = 2'b00,
    PAR_EVEN  = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_mode_e;

  typedef enum logic [1:0] {
    RX_IDLE = 2'b00,
    RX_DATA = 2'b01,
    RX_PAR  = 2'b10
  } rx_state_e;

  typedef struct packed {
    logic             par_en;
    par_mode_e        mode;
    logic [LEN_W-1:0] len;
  } par_cfg_t;

  // Turn the raw XOR of the data bits into the parity bit for a given mode.
  function automatic logic par_apply(input par_mode_e mode, input logic xor_bit);
    logic p;
    case (mode)
      PAR_ODD:  p = ~xor_bit;
      PAR_EVEN: p = xor_bit;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/parity_tree.sv
// Combinational XOR of the low `len` bits of a MAX_WIDTH-bit word; bits at or
// above `len` do not contribute.
module parity_tree
  import uart_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = 9
) (
  input  logic [MAX_WIDTH-1:0] data,
  input  logic [LEN_W-1:0]     len,
  output logic                 xor_c
);

  always_comb begin
    xor_c = 1'b0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (LEN_W'(i) < len) xor_c = xor_c ^ data[i];
    end
  end

endmodule

// File: rtl/parity_gen_chk.sv
// UART parity unit: one-cycle TX parity generation from a parallel word and a
// serial RX parity checker with frame FSM and saturating error counter.
module parity_gen_chk
  import uart_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = 9,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 PAR_EN,
  input  logic [1:0]           PAR_MODE,
  input  logic [LEN_W-1:0]     DATA_LEN,
  input  logic                 TX_DATA_Valid,
  input  logic [MAX_WIDTH-1:0] TX_P_DATA,
  output logic                 tx_par_bit,
  output logic                 tx_par_valid,
  input  logic                 RX_START,
  input  logic                 RX_BIT_Valid,
  input  logic                 RX_BIT,
  input  logic                 RX_PAR_STRB,
  output logic                 rx_done,
  output logic                 rx_par_err,
  output logic                 rx_len_err,
  input  logic                 CLR_CNT,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WIDTH);

  // Out-of-range lengths (0 or above MAX_WIDTH) fall back to the full width.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return ((len == '0) || (len > MAX_LEN)) ? MAX_LEN : len;
  endfunction

  par_cfg_t cfg_now;
  logic     tx_xor_c;

  assign cfg_now = '{par_en: PAR_EN, mode: par_mode_e'(PAR_MODE), len: eff_len(DATA_LEN)};

  parity_tree #(.MAX_WIDTH(MAX_WIDTH)) u_tree (
    .data  (TX_P_DATA),
    .len   (cfg_now.len),
    .xor_c (tx_xor_c)
  );

  // TX parity register; holds its value between enabled strobes.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      tx_par_bit   <= 1'b0;
      tx_par_valid <= 1'b0;
    end else begin
      tx_par_valid <= TX_DATA_Valid & PAR_EN;
      if (TX_DATA_Valid && PAR_EN) tx_par_bit <= par_apply(cfg_now.mode, tx_xor_c);
    end
  end

  rx_state_e              state, state_d;
  par_cfg_t               cfg_q, cfg_d;
  logic                   acc, acc_d;
  logic [LEN_W-1:0]       bit_cnt, bit_cnt_d;
  logic                   over, over_d;
  logic                   done_d, par_err_d, len_err_d;
  logic [CNT_WIDTH-1:0]   err_cnt_d;

  // RX frame FSM: next-state, accumulator and result pulses.
  always_comb begin
    state_d   = state;
    cfg_d     = cfg_q;
    acc_d     = acc;
    bit_cnt_d = bit_cnt;
    over_d    = over;
    done_d    = 1'b0;
    par_err_d = 1'b0;
    len_err_d = 1'b0;

    if (RX_START) begin
      state_d   = RX_DATA;
      cfg_d     = cfg_now;
      acc_d     = 1'b0;
      bit_cnt_d = '0;
      over_d    = 1'b0;
    end else begin
      case (state)
        RX_DATA: begin
          if (RX_PAR_STRB) begin
            state_d   = RX_IDLE;
            done_d    = 1'b1;
            len_err_d = 1'b1;
          end else if (RX_BIT_Valid) begin
            acc_d     = acc ^ RX_BIT;
            bit_cnt_d = bit_cnt + LEN_W'(1);
            if (bit_cnt_d == cfg_q.len) begin
              if (cfg_q.par_en) begin
                state_d = RX_PAR;
              end else begin
                state_d = RX_IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
        RX_PAR: begin
          if (RX_PAR_STRB) begin
            state_d   = RX_IDLE;
            done_d    = 1'b1;
            par_err_d = (RX_BIT != par_apply(cfg_q.mode, acc));
            len_err_d = over;
          end else if (RX_BIT_Valid) begin
            over_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Error counter: clear wins over count, but a coincident error still counts.
  always_comb begin
    err_cnt_d = err_cnt;
    if (CLR_CNT) begin
      err_cnt_d = CNT_WIDTH'(par_err_d);
    end else if (par_err_d && !(&err_cnt)) begin
      err_cnt_d = err_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= RX_IDLE;
      cfg_q      <= '0;
      acc        <= 1'b0;
      bit_cnt    <= '0;
      over       <= 1'b0;
      rx_done    <= 1'b0;
      rx_par_err <= 1'b0;
      rx_len_err <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state      <= state_d;
      cfg_q      <= cfg_d;
      acc        <= acc_d;
      bit_cnt    <= bit_cnt_d;
      over       <= over_d;
      rx_done    <= done_d;
      rx_par_err <= par_err_d;
      rx_len_err <= len_err_d;
      err_cnt    <= err_cnt_d;
    end
  end

endmodule
